// File: rtl/cnt_pkg.sv
// -----------------------------------------------------------------------------
// cnt_pkg
// Shared types and helpers for the nested down-counter (cnt_down_nest).
//   cnt_state_e : controller state, IDLE or RUN
//   PKG_VEC_W   : widest packed level vector lvl_slice can take apart
//   lvl_slice   : returns a packed vector shifted so level idx sits in the
//                 low bits; callers narrow the result with a size cast
// -----------------------------------------------------------------------------
package cnt_pkg;

    typedef enum logic {
        CNT_IDLE = 1'b0,
        CNT_RUN  = 1'b1
    } cnt_state_e;

    // Upper bound on NUM_LVL*CNT_WIDTH for any instance using lvl_slice.
    localparam int PKG_VEC_W = 256;

    // Brings field idx (each field width bits wide) down to bit 0. The caller
    // truncates to its own field width, so the helper stays width-agnostic.
    function automatic logic [PKG_VEC_W-1:0] lvl_slice(
        input logic [PKG_VEC_W-1:0] vec,
        input int                   idx,
        input int                   width
    );
        return vec >> (idx * width);
    endfunction

endpackage

// File: rtl/cnt_down_lvl.sv
// -----------------------------------------------------------------------------
// cnt_down_lvl
// One level of the nested down-counter. When carry_in_i is high the level
// acts: it decrements if nonzero or reloads ld_val_i if zero. A zero count
// with carry_in_i high passes the carry on to the next outer level.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset, count -> 0
//   clr_i        synchronous clear, count -> 0 (highest synchronous priority)
//   ld_i         synchronous load of ld_val_i
//   ld_val_i     load / reload value for this level
//   carry_in_i   this level acts on the current step
//   carry_out_o  this level is at zero and acting, i.e. it wraps
//   cnt_o        current count of this level
// -----------------------------------------------------------------------------
module cnt_down_lvl #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 ld_i,
    input  logic [CNT_WIDTH-1:0] ld_val_i,
    input  logic                 carry_in_i,
    output logic                 carry_out_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 is_zero;

    assign is_zero     = (cnt_q == '0);
    assign carry_out_o = carry_in_i && is_zero;
    assign cnt_o       = cnt_q;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d; a missing branch
        // would otherwise infer a latch.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (carry_in_i) begin
            // Wrap reloads the live ld_val_i, so a reload samples it too.
            cnt_d = is_zero ? ld_val_i : cnt_q - CNT_WIDTH'(1);
        end
    end

    // NOTE: the counter is control state, so it gets the async reset; state
    // registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cnt_down_nest.sv
// -----------------------------------------------------------------------------
// cnt_down_nest
// NUM_LVL cascaded down-counters producing nested loop indices. Level 0 is
// innermost. One iteration takes prod(ld_val[i]+1) steps; the last step
// either reloads everything (auto mode) or stops in IDLE (one-shot mode).
// Ports:
//   cnt_clk       clock, rising edge
//   cnt_rst       asynchronous active-high reset
//   cnt_ld        load all levels from cnt_ld_val and enter RUN
//   cnt_ld_val    packed load values, level i at [i*CNT_WIDTH +: CNT_WIDTH]
//   cnt_en        advance enable; low stalls every level
//   cnt_auto      1: reload after the terminal count, 0: stop in IDLE
//   cnt_clr       synchronous clear to IDLE with all counts 0
//   cnt           packed current level counts
//   cnt_lvl_wrap  level i wraps on this step (combinational)
//   cnt_last      RUN with all levels at zero (combinational)
//   cnt_busy      state is RUN
//   cnt_done      registered one-cycle pulse after the terminal step
// Priority: cnt_rst > cnt_clr > cnt_ld > step.
// -----------------------------------------------------------------------------
module cnt_down_nest
    import cnt_pkg::*;
#(
    parameter int CNT_WIDTH = 4,
    parameter int NUM_LVL   = 3
) (
    input  logic                         cnt_clk,
    input  logic                         cnt_rst,
    input  logic                         cnt_ld,
    input  logic [NUM_LVL*CNT_WIDTH-1:0] cnt_ld_val,
    input  logic                         cnt_en,
    input  logic                         cnt_auto,
    input  logic                         cnt_clr,
    output logic [NUM_LVL*CNT_WIDTH-1:0] cnt,
    output logic [NUM_LVL-1:0]           cnt_lvl_wrap,
    output logic                         cnt_last,
    output logic                         cnt_busy,
    output logic                         cnt_done
);

    cnt_state_e           state_q;
    cnt_state_e           state_d;
    logic                 done_q;
    logic                 done_d;

    logic                 step;       // RUN and enabled
    logic [NUM_LVL:0]     carry;      // carry[i] = level i acts this step
    logic                 terminal;   // terminal step that is not overridden
    logic                 lvl_clr;    // clear request seen by every level
    logic [PKG_VEC_W-1:0] ld_val_ext;

    assign step       = (state_q == CNT_RUN) && cnt_en;
    assign carry[0]   = step;
    assign ld_val_ext = PKG_VEC_W'(cnt_ld_val);

    // All levels at zero means the carry ripples out of the outermost level.
    // A clear or load in the same cycle wins and discards the terminal step.
    assign terminal = carry[NUM_LVL] && !cnt_clr && !cnt_ld;

    // In one-shot mode the terminal step must leave the levels at zero rather
    // than let them reload; they are all zero already, so a clear does it.
    assign lvl_clr = cnt_clr || (terminal && !cnt_auto);

    // -------------------------------------------------------------------------
    // Level chain
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_LVL; i++) begin : g_lvl
        logic [CNT_WIDTH-1:0] ld_val_lvl;

        assign ld_val_lvl = CNT_WIDTH'(lvl_slice(ld_val_ext, i, CNT_WIDTH));

        cnt_down_lvl #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_lvl (
            .clk_i       (cnt_clk),
            .rst_i       (cnt_rst),
            .clr_i       (lvl_clr),
            .ld_i        (cnt_ld),
            .ld_val_i    (ld_val_lvl),
            .carry_in_i  (carry[i]),
            .carry_out_o (carry[i+1]),
            .cnt_o       (cnt[i*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    // A level wraps exactly when it hands its carry to the next level.
    assign cnt_lvl_wrap = carry[NUM_LVL:1];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge cnt_clk or posedge cnt_rst) begin
        if (cnt_rst) begin
            state_q <= CNT_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        done_d  = terminal;
        if (cnt_clr) begin
            state_d = CNT_IDLE;
        end else if (cnt_ld) begin
            state_d = CNT_RUN;
        end else if (terminal && !cnt_auto) begin
            state_d = CNT_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_busy = (state_q == CNT_RUN);
        cnt_last = (state_q == CNT_RUN) && (cnt == '0);
        cnt_done = done_q;
    end

endmodule

// File: tb/tb_cnt_down_nest.sv
// -----------------------------------------------------------------------------
// tb_cnt_down_nest
// Self-checking bench for cnt_down_nest (NUM_LVL=3, CNT_WIDTH=4). The
// reference model tracks only "steps taken since load" and derives counts,
// wraps and last from mixed-radix arithmetic on the remaining step count.
// -----------------------------------------------------------------------------
module tb_cnt_down_nest;

    localparam int NL = 3;
    localparam int W  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            ld;
    logic [NL*W-1:0] ld_val;
    logic            en;
    logic            auto_m;
    logic            clr;
    logic [NL*W-1:0] cnt;
    logic [NL-1:0]   wrap;
    logic            last;
    logic            busy;
    logic            done;

    int n_checks = 0;
    int n_pass   = 0;

    cnt_down_nest #(
        .CNT_WIDTH (W),
        .NUM_LVL   (NL)
    ) dut (
        .cnt_clk      (clk),
        .cnt_rst      (rst),
        .cnt_ld       (ld),
        .cnt_ld_val   (ld_val),
        .cnt_en       (en),
        .cnt_auto     (auto_m),
        .cnt_clr      (clr),
        .cnt          (cnt),
        .cnt_lvl_wrap (wrap),
        .cnt_last     (last),
        .cnt_busy     (busy),
        .cnt_done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: busy flag, steps since load, latched load values
    // -------------------------------------------------------------------------
    bit m_busy     = 1'b0;
    int m_k        = 0;
    bit m_done     = 1'b0;
    int m_lv [NL]  = '{default: 0};

    function automatic int period();
        int p = 1;
        for (int i = 0; i < NL; i++) p *= m_lv[i] + 1;
        return p;
    endfunction

    function automatic logic [NL*W-1:0] digits(input int r);
        logic [NL*W-1:0] e = '0;
        int div = 1;
        for (int i = 0; i < NL; i++) begin
            e[W*i +: W] = W'((r / div) % (m_lv[i] + 1));
            div *= m_lv[i] + 1;
        end
        return e;
    endfunction

    // Level i wraps when the remaining count is a multiple of the product of
    // radices of levels 0..i.
    function automatic logic [NL-1:0] exp_wrap(input int r, input bit stp);
        logic [NL-1:0] e = '0;
        int div = 1;
        for (int i = 0; i < NL; i++) begin
            div *= m_lv[i] + 1;
            e[i] = stp && (r % div == 0);
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_k    <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (clr) begin
                m_busy <= 1'b0;
            end else if (ld) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                for (int i = 0; i < NL; i++) m_lv[i] <= int'(ld_val[W*i +: W]);
            end else if (m_busy && en) begin
                if (m_k == period() - 1) begin
                    m_done <= 1'b1;
                    if (auto_m) m_k <= 0;
                    else m_busy <= 1'b0;
                end else begin
                    m_k <= m_k + 1;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        int r;
        r = period() - 1 - m_k;
        check("cnt",  32'(cnt),  m_busy ? 32'(digits(r)) : 32'd0);
        check("wrap", 32'(wrap), m_busy ? 32'(exp_wrap(r, en)) : 32'd0);
        check("last", 32'(last), 32'(m_busy && r == 0));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    logic [NL*W-1:0] o_first, o_second;
    int              o_done_cyc, o_ndone, o_steps, o_w0, o_w1, o_w2;
    logic [NL-1:0]   o_wrap_before_done;
    logic            o_busy_at_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [NL*W-1:0] val, input logic a);
        ld_val = val;
        auto_m = a;
        ld     = 1'b1;
        tick();
        ld     = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Observes up to ncyc cycles (cycle 1 is the first after the call).
    // en_mode 0: enable always high; 1: high on one cycle in three.
    task automatic run_obs(input int ncyc, input int en_mode, input bit stop_on_done);
        logic [NL-1:0] prev_wrap = '0;
        o_first = '0; o_second = '0; o_done_cyc = -1; o_ndone = 0; o_steps = 0;
        o_w0 = 0; o_w1 = 0; o_w2 = 0; o_wrap_before_done = '0; o_busy_at_done = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            en = (en_mode == 0) ? 1'b1 : (c % 3 == 1);
            @(negedge clk);
            if (c == 1) o_first = cnt;
            if (c == 2) o_second = cnt;
            if (done) begin
                o_ndone++;
                if (o_done_cyc < 0) begin
                    o_done_cyc         = c;
                    o_wrap_before_done = prev_wrap;
                    o_busy_at_done     = busy;
                end
            end
            if (busy && en) o_steps++;
            o_w0 += int'(wrap[0]);
            o_w1 += int'(wrap[1]);
            o_w2 += int'(wrap[2]);
            prev_wrap = wrap;
            tick();
            if (stop_on_done && o_done_cyc > 0) break;
        end
    endtask

    function automatic logic [NL*W-1:0] rnd_val();
        return {W'($urandom_range(0, 3)), W'($urandom_range(0, 3)), W'($urandom_range(0, 3))};
    endfunction

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        rst = 1'b1; ld = 1'b0; ld_val = '0; en = 1'b0; auto_m = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_cnt",  32'(cnt),  32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // One-shot, (1,2,3), enable held high: 24 steps, done in cycle 25.
        do_load(12'h123, 1'b0);
        run_obs(60, 0, 1'b1);
        check("t1_first",     32'(o_first),  32'h123);
        check("t1_second",    32'(o_second), 32'h122);
        check("t1_done_cyc",  32'(o_done_cyc), 32'd25);
        check("t1_wrap0",     32'(o_w0), 32'd6);
        check("t1_wrap1",     32'(o_w1), 32'd2);
        check("t1_wrap2",     32'(o_w2), 32'd1);
        check("t1_busy_done", 32'(o_busy_at_done), 32'd0);
        run_obs(5, 0, 1'b0);
        check("t1_no_more_done", 32'(o_ndone), 32'd0);
        check("t1_idle",         32'(busy),    32'd0);

        // Enable 1-on/2-off: done right after the 24th enabled step.
        do_load(12'h123, 1'b0);
        run_obs(100, 1, 1'b1);
        check("t2_steps",    32'(o_steps), 32'd24);
        check("t2_done_cyc", 32'(o_done_cyc), 32'd71);

        // Auto reload: three periods, three done pulses, always busy.
        do_load(12'h123, 1'b1);
        run_obs(73, 0, 1'b0);
        check("t3_ndone", 32'(o_ndone), 32'd3);
        check("t3_busy",  32'(busy), 32'd1);
        pulse_clr();
        check("t3_clr_idle", 32'(busy), 32'd0);

        // Outer levels of zero: 6 steps, all wraps on the sixth.
        do_load(12'h005, 1'b0);
        run_obs(20, 0, 1'b1);
        check("t4_done_cyc", 32'(o_done_cyc), 32'd7);
        check("t4_all_wrap", 32'(o_wrap_before_done), 32'h7);

        // All-zero load: a single step, then done.
        do_load(12'h000, 1'b0);
        run_obs(10, 0, 1'b1);
        check("t5_done_cyc", 32'(o_done_cyc), 32'd2);
        check("t5_steps",    32'(o_steps), 32'd1);

        // Reset for three cycles mid-run.
        do_load(12'h123, 1'b0);
        run_obs(10, 0, 1'b0);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("t6_rst_cnt",  32'(cnt),  32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        run_obs(30, 0, 1'b0);
        check("t6_rst_no_done", 32'(o_ndone), 32'd0);
        do_load(12'h123, 1'b0);
        run_obs(2, 0, 1'b0);
        check("t6_reload", 32'(o_first), 32'h123);
        pulse_clr();

        // Synchronous clear mid-run.
        do_load(12'h123, 1'b0);
        run_obs(10, 0, 1'b0);
        pulse_clr();
        check("t7_clr_cnt",  32'(cnt),  32'd0);
        check("t7_clr_busy", 32'(busy), 32'd0);
        run_obs(30, 0, 1'b0);
        check("t7_clr_no_done", 32'(o_ndone), 32'd0);
        do_load(12'h123, 1'b0);
        run_obs(2, 0, 1'b0);
        check("t7_reload", 32'(o_first), 32'h123);
        pulse_clr();

        // Load at (0,0,0) with enable high: load wins, no done.
        do_load(12'h123, 1'b0);
        run_obs(23, 0, 1'b0);
        check("t8_at_zero", 32'(cnt), 32'd0);
        en = 1'b1;
        do_load(12'h021, 1'b0);
        run_obs(3, 0, 1'b0);
        check("t8_restart", 32'(o_first), 32'h021);
        check("t8_no_done", 32'(o_ndone), 32'd0);
        pulse_clr();

        // Randomised traffic, checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 59) == 0);
            ld  = m_busy ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
            if (ld) ld_val = rnd_val();
            en = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) auto_m = ~auto_m;
            tick();
        end
        rst = 1'b0; clr = 1'b0; ld = 1'b0; en = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
